// File: rtl/uart_rx_controller.sv
// 8N1 UART receiver: synchronises the serial line, verifies the start bit at
// mid-bit, samples each data bit at its centre and reports framing errors.
module uart_rx_controller #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_Rx_Serial,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Valid,
    output logic       o_Rx_Active,
    output logic       o_Rx_Frame_Err,
    output logic [2:0] dbg_state
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT + 1);

    localparam logic [CW-1:0] HALF_CNT = CW'(HALF);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = '0;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          sync_meta;
    logic          rx_sync;
    logic [CW-1:0] clk_cnt;
    logic [CW-1:0] clk_cnt_next;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_next;
    logic [7:0]    shift;
    logic [7:0]    shift_next;
    logic [7:0]    byte_next;
    logic          valid_next;
    logic          active_next;
    logic          err_next;

    assign dbg_state = state;

    // Synchroniser resets to the idle (high) level so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= 1'b1;
            rx_sync   <= 1'b1;
        end else begin
            sync_meta <= i_Rx_Serial;
            rx_sync   <= sync_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            clk_cnt        <= CNT_ZERO;
            bit_idx        <= 3'd0;
            shift          <= 8'h00;
            o_Rx_Byte      <= 8'h00;
            o_Rx_Valid     <= 1'b0;
            o_Rx_Active    <= 1'b0;
            o_Rx_Frame_Err <= 1'b0;
        end else begin
            state          <= state_next;
            clk_cnt        <= clk_cnt_next;
            bit_idx        <= bit_idx_next;
            shift          <= shift_next;
            o_Rx_Byte      <= byte_next;
            o_Rx_Valid     <= valid_next;
            o_Rx_Active    <= active_next;
            o_Rx_Frame_Err <= err_next;
        end
    end

    always_comb begin
        state_next   = state;
        clk_cnt_next = clk_cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        byte_next    = o_Rx_Byte;
        valid_next   = 1'b0;
        err_next     = 1'b0;
        active_next  = o_Rx_Active;

        case (state)
            IDLE: begin
                active_next = 1'b0;
                if (!rx_sync) begin
                    state_next   = START;
                    clk_cnt_next = CNT_ONE;
                    active_next  = 1'b1;
                end
            end

            START: begin
                if (clk_cnt == HALF_CNT) begin
                    if (!rx_sync) begin
                        state_next   = DATA;
                        clk_cnt_next = CNT_ZERO;
                        bit_idx_next = 3'd0;
                    end else begin
                        // Line went back high before mid-bit: treat as a glitch.
                        state_next  = IDLE;
                        active_next = 1'b0;
                    end
                end else begin
                    clk_cnt_next = clk_cnt + CNT_ONE;
                end
            end

            DATA: begin
                if (clk_cnt == LAST_CNT) begin
                    shift_next[bit_idx] = rx_sync;
                    clk_cnt_next        = CNT_ZERO;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    clk_cnt_next = clk_cnt + CNT_ONE;
                end
            end

            STOP: begin
                if (clk_cnt == LAST_CNT) begin
                    if (rx_sync) begin
                        byte_next   = shift;
                        valid_next  = 1'b1;
                        state_next  = IDLE;
                        active_next = 1'b0;
                    end else begin
                        err_next   = 1'b1;
                        state_next = WAIT_HIGH;
                    end
                end else begin
                    clk_cnt_next = clk_cnt + CNT_ONE;
                end
            end

            WAIT_HIGH: begin
                // A held-low (break) line parks here instead of re-triggering a start.
                active_next = 1'b1;
                if (rx_sync) begin
                    state_next  = IDLE;
                    active_next = 1'b0;
                end
            end

            default: begin
                state_next  = IDLE;
                active_next = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_controller.sv
// Bench for uart_rx_controller: drives 8N1 frames into a 16x and a 4x instance
// and scores received bytes and pulse edges against an expected queue.
module tb_uart_rx_controller;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx16    = 1'b1;
    logic       rx4     = 1'b1;
    int         cyc     = 0;

    logic [7:0] b16, b4;
    logic       v16, v4, a16, a4, fe16, fe4;
    logic [2:0] dbg16, dbg4;

    int compared   = 0;
    int mismatched = 0;

    // Scoreboard: expected bytes and the edge number of their valid pulse.
    logic [7:0] exp_q[$];
    int         exp_e_q[$];

    // Observed events, appended by the monitor, consumed through read pointers.
    logic [7:0] got16_b[$];
    int         got16_e[$];
    logic [7:0] got4_b[$];
    int         got4_e[$];
    int         err16_e[$];
    int         act16_e[$];
    logic       act16_v[$];
    logic       act16_prev = 1'b0;
    int         rd16 = 0;
    int         rd4  = 0;

    uart_rx_controller #(.CLKS_PER_BIT(16)) dut16 (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_Rx_Serial   (rx16),
        .o_Rx_Byte     (b16),
        .o_Rx_Valid    (v16),
        .o_Rx_Active   (a16),
        .o_Rx_Frame_Err(fe16),
        .dbg_state     (dbg16)
    );

    uart_rx_controller #(.CLKS_PER_BIT(4)) dut4 (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_Rx_Serial   (rx4),
        .o_Rx_Byte     (b4),
        .o_Rx_Valid    (v4),
        .o_Rx_Active   (a4),
        .o_Rx_Frame_Err(fe4),
        .dbg_state     (dbg4)
    );

    // Clock and edge numbering: after rising edge N, cyc == N.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (v16) begin
            got16_b.push_back(b16);
            got16_e.push_back(cyc);
        end
        if (v4) begin
            got4_b.push_back(b4);
            got4_e.push_back(cyc);
        end
        if (fe16) err16_e.push_back(cyc);
        if (a16 !== act16_prev) begin
            act16_e.push_back(cyc);
            act16_v.push_back(a16);
        end
        act16_prev <= a16;
    end

    // Driver: called 1 time unit after a rising edge; returns aligned the same way.
    // e0 is the first edge that samples the start bit.
    task automatic send_frame(input bit use4, input logic [7:0] data, input logic stop_bit,
                              output int e0);
        int         cpb;
        logic [9:0] bits;
        cpb  = use4 ? 4 : 16;
        bits = {stop_bit, data, 1'b0};
        e0   = cyc + 1;
        for (int k = 0; k < 10; k++) begin
            if (use4) rx4 = bits[k];
            else      rx16 = bits[k];
            repeat (cpb) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        rx16    = 1'b1;
        rx4     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        compared += 6;
        if (b16 !== 8'h00) begin mismatched++; $display("FAIL reset_byte: got %02h expected 00", b16); end
        if (v16 !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b expected 0", v16); end
        if (a16 !== 1'b0) begin mismatched++; $display("FAIL reset_active: got %b expected 0", a16); end
        if (fe16 !== 1'b0) begin mismatched++; $display("FAIL reset_frame_err: got %b expected 0", fe16); end
        if (dbg16 !== 3'd0) begin mismatched++; $display("FAIL reset_state: got %0d expected 0", dbg16); end
        if (b4 !== 8'h00) begin mismatched++; $display("FAIL reset_byte4: got %02h expected 00", b4); end
        reset_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        compared += 2;
        if (a16 !== 1'b0) begin mismatched++; $display("FAIL release_active: got %b expected 0", a16); end
        if (got16_b.size() != 0 || err16_e.size() != 0) begin
            mismatched++;
            $display("FAIL release_pulses: got %0d valid %0d err expected 0 0", got16_b.size(), err16_e.size());
        end
    endtask

    task automatic test_single;
        int e0, a0, f0, ee;
        logic [7:0] eb;
        a0 = act16_e.size();
        f0 = err16_e.size();
        exp_q.push_back(8'hA5);
        exp_e_q.push_back(cyc + 1 + 154);
        send_frame(1'b0, 8'hA5, 1'b1, e0);
        repeat (10) @(posedge clk);
        #1;
        compared++;
        if (b16 !== 8'hA5) begin mismatched++; $display("FAIL single_byte_held: got %02h expected a5", b16); end
        while (exp_q.size() > 0) begin
            eb = exp_q.pop_front();
            ee = exp_e_q.pop_front();
            compared += 2;
            if (rd16 >= got16_b.size()) begin
                mismatched += 2;
                $display("FAIL single_valid: no pulse, expected %02h at E%0d", eb, ee - e0);
            end else begin
                if (got16_b[rd16] !== eb) begin mismatched++; $display("FAIL single_byte: got %02h expected %02h", got16_b[rd16], eb); end
                if (got16_e[rd16] != ee) begin mismatched++; $display("FAIL single_valid_edge: got E%0d expected E%0d", got16_e[rd16] - e0, ee - e0); end
                rd16++;
            end
        end
        compared++;
        if (rd16 != got16_b.size()) begin
            mismatched++;
            $display("FAIL single_extra_valid: got %0d extra pulses expected 0", got16_b.size() - rd16);
            rd16 = got16_b.size();
        end
        compared++;
        if (err16_e.size() != f0) begin mismatched++; $display("FAIL single_frame_err: got %0d pulses expected 0", err16_e.size() - f0); end
        compared++;
        if (act16_e.size() - a0 != 2) begin
            mismatched++;
            $display("FAIL single_active_count: got %0d transitions expected 2", act16_e.size() - a0);
        end else begin
            compared++;
            if (act16_e[a0] != e0 + 2 || act16_v[a0] !== 1'b1 || act16_e[a0+1] != e0 + 154 || act16_v[a0+1] !== 1'b0) begin
                mismatched++;
                $display("FAIL single_active_window: got rise E%0d fall E%0d expected E2 E154", act16_e[a0] - e0, act16_e[a0+1] - e0);
            end
        end
    endtask

    task automatic test_back_to_back;
        int e0, e1, ee;
        logic [7:0] eb;
        exp_q.push_back(8'h00);
        exp_e_q.push_back(cyc + 1 + 154);
        exp_q.push_back(8'hFF);
        exp_e_q.push_back(cyc + 1 + 160 + 154);
        send_frame(1'b0, 8'h00, 1'b1, e0);
        send_frame(1'b0, 8'hFF, 1'b1, e1);
        repeat (10) @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            eb = exp_q.pop_front();
            ee = exp_e_q.pop_front();
            compared += 2;
            if (rd16 >= got16_b.size()) begin
                mismatched += 2;
                $display("FAIL b2b_valid: no pulse, expected %02h at E%0d", eb, ee - e0);
            end else begin
                if (got16_b[rd16] !== eb) begin mismatched++; $display("FAIL b2b_byte: got %02h expected %02h", got16_b[rd16], eb); end
                if (got16_e[rd16] != ee) begin mismatched++; $display("FAIL b2b_valid_edge: got E%0d expected E%0d", got16_e[rd16] - e0, ee - e0); end
                rd16++;
            end
        end
        compared++;
        if (rd16 != got16_b.size()) begin
            mismatched++;
            $display("FAIL b2b_extra_valid: got %0d extra pulses expected 0", got16_b.size() - rd16);
            rd16 = got16_b.size();
        end
    endtask

    task automatic test_glitch;
        int e0, a0, f0;
        a0 = act16_e.size();
        f0 = err16_e.size();
        e0 = cyc + 1;
        rx16 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx16 = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        compared += 3;
        if (b16 !== 8'hFF) begin mismatched++; $display("FAIL glitch_byte_held: got %02h expected ff", b16); end
        if (rd16 != got16_b.size()) begin
            mismatched++;
            $display("FAIL glitch_valid: got %0d pulses expected 0", got16_b.size() - rd16);
            rd16 = got16_b.size();
        end
        if (err16_e.size() != f0) begin mismatched++; $display("FAIL glitch_frame_err: got %0d pulses expected 0", err16_e.size() - f0); end
        compared++;
        if (act16_e.size() - a0 != 2) begin
            mismatched++;
            $display("FAIL glitch_active_count: got %0d transitions expected 2", act16_e.size() - a0);
        end else begin
            compared++;
            if (act16_e[a0] != e0 + 2 || act16_e[a0+1] != e0 + 10 || act16_v[a0+1] !== 1'b0) begin
                mismatched++;
                $display("FAIL glitch_active_window: got rise E%0d fall E%0d expected E2 E10", act16_e[a0] - e0, act16_e[a0+1] - e0);
            end
        end
    endtask

    task automatic test_frame_error;
        int e0, e1, e2, a0, f0, x, ee;
        logic [7:0] eb;
        exp_q.push_back(8'h11);
        exp_e_q.push_back(cyc + 1 + 154);
        send_frame(1'b0, 8'h11, 1'b1, e0);
        a0 = act16_e.size();
        f0 = err16_e.size();
        send_frame(1'b0, 8'h3C, 1'b0, e1);
        repeat (40) @(posedge clk);
        #1;
        compared++;
        if (a16 !== 1'b1) begin mismatched++; $display("FAIL ferr_active_in_break: got %b expected 1", a16); end
        x = cyc;
        rx16 = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        compared += 2;
        if (b16 !== 8'h11) begin mismatched++; $display("FAIL ferr_byte_held: got %02h expected 11", b16); end
        if (err16_e.size() - f0 != 1) begin
            mismatched++;
            $display("FAIL ferr_pulse_count: got %0d expected 1", err16_e.size() - f0);
        end else begin
            compared++;
            if (err16_e[f0] != e1 + 154) begin mismatched++; $display("FAIL ferr_edge: got E%0d expected E154", err16_e[f0] - e1); end
        end
        compared++;
        if (act16_e.size() - a0 != 2) begin
            mismatched++;
            $display("FAIL ferr_active_count: got %0d transitions expected 2", act16_e.size() - a0);
        end else begin
            compared++;
            if (act16_e[a0] != e1 + 2 || act16_e[a0+1] != x + 3) begin
                mismatched++;
                $display("FAIL ferr_active_window: got rise E%0d fall %0d expected E2 %0d", act16_e[a0] - e1, act16_e[a0+1], x + 3);
            end
        end
        repeat (5) @(posedge clk);
        #1;
        exp_q.push_back(8'h81);
        exp_e_q.push_back(cyc + 1 + 154);
        send_frame(1'b0, 8'h81, 1'b1, e2);
        repeat (10) @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            eb = exp_q.pop_front();
            ee = exp_e_q.pop_front();
            compared += 2;
            if (rd16 >= got16_b.size()) begin
                mismatched += 2;
                $display("FAIL ferr_valid: no pulse, expected %02h at edge %0d", eb, ee);
            end else begin
                if (got16_b[rd16] !== eb) begin mismatched++; $display("FAIL ferr_rx_byte: got %02h expected %02h", got16_b[rd16], eb); end
                if (got16_e[rd16] != ee) begin mismatched++; $display("FAIL ferr_valid_edge: got %0d expected %0d", got16_e[rd16], ee); end
                rd16++;
            end
        end
        compared++;
        if (rd16 != got16_b.size()) begin
            mismatched++;
            $display("FAIL ferr_extra_valid: got %0d extra pulses expected 0", got16_b.size() - rd16);
            rd16 = got16_b.size();
        end
    endtask

    task automatic test_reset_mid_frame;
        int e0, edummy, f0, ee;
        logic [7:0] eb;
        f0 = err16_e.size();
        fork
            send_frame(1'b0, 8'h77, 1'b1, edummy);
            begin
                // Lands inside data bit 4 of the frame.
                repeat (86) @(posedge clk);
                #1;
                reset_n = 1'b0;
                #1;
                compared += 4;
                if (b16 !== 8'h00) begin mismatched++; $display("FAIL rst_mid_byte: got %02h expected 00", b16); end
                if (v16 !== 1'b0) begin mismatched++; $display("FAIL rst_mid_valid: got %b expected 0", v16); end
                if (a16 !== 1'b0) begin mismatched++; $display("FAIL rst_mid_active: got %b expected 0", a16); end
                if (fe16 !== 1'b0) begin mismatched++; $display("FAIL rst_mid_frame_err: got %b expected 0", fe16); end
            end
        join
        reset_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        compared += 2;
        if (rd16 != got16_b.size()) begin
            mismatched++;
            $display("FAIL rst_spurious_valid: got %0d pulses expected 0", got16_b.size() - rd16);
            rd16 = got16_b.size();
        end
        if (err16_e.size() != f0) begin mismatched++; $display("FAIL rst_spurious_err: got %0d pulses expected 0", err16_e.size() - f0); end
        exp_q.push_back(8'h5A);
        exp_e_q.push_back(cyc + 1 + 154);
        send_frame(1'b0, 8'h5A, 1'b1, e0);
        repeat (10) @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            eb = exp_q.pop_front();
            ee = exp_e_q.pop_front();
            compared += 2;
            if (rd16 >= got16_b.size()) begin
                mismatched += 2;
                $display("FAIL rst_valid: no pulse, expected %02h at E%0d", eb, ee - e0);
            end else begin
                if (got16_b[rd16] !== eb) begin mismatched++; $display("FAIL rst_byte: got %02h expected %02h", got16_b[rd16], eb); end
                if (got16_e[rd16] != ee) begin mismatched++; $display("FAIL rst_valid_edge: got E%0d expected E%0d", got16_e[rd16] - e0, ee - e0); end
                rd16++;
            end
        end
        compared++;
        if (rd16 != got16_b.size()) begin
            mismatched++;
            $display("FAIL rst_extra_valid: got %0d extra pulses expected 0", got16_b.size() - rd16);
            rd16 = got16_b.size();
        end
    endtask

    task automatic test_fast_instance;
        int e0, ee;
        logic [7:0] eb;
        exp_q.push_back(8'hC3);
        exp_e_q.push_back(cyc + 1 + 40);
        send_frame(1'b1, 8'hC3, 1'b1, e0);
        repeat (6) @(posedge clk);
        #1;
        compared++;
        if (b4 !== 8'hC3) begin mismatched++; $display("FAIL fast_byte_held: got %02h expected c3", b4); end
        while (exp_q.size() > 0) begin
            eb = exp_q.pop_front();
            ee = exp_e_q.pop_front();
            compared += 2;
            if (rd4 >= got4_b.size()) begin
                mismatched += 2;
                $display("FAIL fast_valid: no pulse, expected %02h at E%0d", eb, ee - e0);
            end else begin
                if (got4_b[rd4] !== eb) begin mismatched++; $display("FAIL fast_byte: got %02h expected %02h", got4_b[rd4], eb); end
                if (got4_e[rd4] != ee) begin mismatched++; $display("FAIL fast_valid_edge: got E%0d expected E%0d", got4_e[rd4] - e0, ee - e0); end
                rd4++;
            end
        end
        compared++;
        if (rd4 != got4_b.size()) begin
            mismatched++;
            $display("FAIL fast_extra_valid: got %0d extra pulses expected 0", got4_b.size() - rd4);
            rd4 = got4_b.size();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_reset_mid_frame();
        test_fast_instance();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_rx_controller.md
Name: uart_rx_controller

Overview:
- Receive half of the UART link: deserialises 8N1 frames (start bit, 8 data bits LSB-first, 1 stop bit) from an asynchronous serial line into bytes.
- Sits between the board pin and the byte consumer, opposite the TX controller.
- Synchronises the line, rejects start-bit glitches, samples mid-bit, and flags framing errors.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per serial bit. Legal range 4..65535. Must match the far-end bit period.
- HALF (localparam), CLKS_PER_BIT/2 (integer division): mid-bit sample offset.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- i_Rx_Serial  input  1  asynchronous serial line; idles high.
- o_Rx_Byte  output  8  last correctly framed byte; held until the next good frame.
- o_Rx_Valid  output  1  one-cycle pulse when o_Rx_Byte is updated.
- o_Rx_Active  output  1  high while a frame is being received.
- o_Rx_Frame_Err  output  1  one-cycle pulse when the stop bit is sampled low.

Behaviour:
- Reset values:
  - o_Rx_Byte=0x00; o_Rx_Valid=0; o_Rx_Active=0; o_Rx_Frame_Err=0.
  - Both synchroniser flops = 1, so no false start on reset release.
  - State=IDLE; bit counter=0; clock counter=0; shift register=0x00.
- Reset asserted mid-frame aborts the frame immediately. Nothing is emitted.
- Synchroniser: 2-flop chain on i_Rx_Serial; its output is rx_sync. All decisions use rx_sync only.
- o_Rx_Valid and o_Rx_Frame_Err default to 0 every cycle. Each is asserted for exactly one cycle.
- States: IDLE, START, DATA, STOP, WAIT_HIGH. Any other encoding -> IDLE.
- IDLE:
  - o_Rx_Active=0.
  - rx_sync==0 -> START, clock counter <= 1, o_Rx_Active <= 1.
- START:
  - When clock counter == HALF:
    - rx_sync==0 -> DATA, clock counter <= 0, bit index <= 0.
    - rx_sync==1 -> glitch; go to IDLE, o_Rx_Active <= 0, no pulse.
  - Otherwise increment the clock counter.
- DATA:
  - When clock counter == CLKS_PER_BIT-1: shift[bit index] <= rx_sync, clock counter <= 0.
    - bit index==7 -> STOP.
    - Otherwise increment bit index.
  - Otherwise increment the clock counter.
- STOP:
  - When clock counter == CLKS_PER_BIT-1:
    - rx_sync==1 -> o_Rx_Byte <= shift, o_Rx_Valid <= 1, go to IDLE, o_Rx_Active <= 0.
    - rx_sync==0 -> o_Rx_Frame_Err <= 1, o_Rx_Byte unchanged, go to WAIT_HIGH.
  - Otherwise increment the clock counter.
- WAIT_HIGH:
  - o_Rx_Active stays 1.
  - Exit to IDLE (o_Rx_Active <= 0) only when rx_sync==1.
  - A held-low (break) line never causes a restart.
- Timing: let E0 be the first rising edge at which i_Rx_Serial is sampled low.
  - Start verify occurs at edge E(2+HALF).
  - Data bit n is sampled at edge E(2+HALF+(n+1)*CLKS_PER_BIT).
  - The stop bit, and the o_Rx_Valid or o_Rx_Frame_Err pulse, occur at edge E(2+HALF+9*CLKS_PER_BIT).
- Back-to-back frames: the receiver is back in IDLE before the next start bit can reach rx_sync. A continuous stream with no idle gap is received with no loss.
- Counter width: clog2(CLKS_PER_BIT+1) bits. The counter never wraps within a bit.

Test Plan:
1. CLKS_PER_BIT=16. Send 0xA5 -> o_Rx_Byte=0xA5, o_Rx_Valid high for exactly one cycle at E154, o_Rx_Frame_Err never high, o_Rx_Active high from E2 to E154.
2. Send 0x00 then 0xFF back-to-back with no idle gap -> two o_Rx_Valid pulses exactly 160 cycles apart, carrying bytes 0x00 then 0xFF.
3. Drive the line low for 4 cycles, then high -> o_Rx_Active pulses high for edges E2..E10, then low. No valid pulse, no error, o_Rx_Byte unchanged.
4. Receive 0x11. Then send 0x3C with the stop bit low and hold the line low 40 further cycles -> o_Rx_Frame_Err pulses at E154, o_Rx_Byte stays 0x11, no new start while the line is low. After the line returns high, 0x81 is received correctly.
5. Pull reset_n low during data bit 4 of a frame -> all outputs 0 immediately. After release with the line idle, 0x5A is received correctly with no spurious pulse.
6. CLKS_PER_BIT=4 instance. Send 0xC3 -> o_Rx_Byte=0xC3, o_Rx_Valid pulses at E40.
